// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD text writer.
// LCD_WRITER_CLEAR_EN (optional) prefixes each refresh with a clear command.
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, HOLD, WAIT, CLR_DLY} state_e;

  localparam logic [9:0] CMD_LINE1 = 10'h080;
  localparam logic [9:0] CMD_LINE2 = 10'h0C0;
  localparam logic [9:0] CMD_CLEAR = 10'h001;

  localparam int RS_BIT    = 9;
  localparam int RW_BIT    = 8;
  localparam int LINE_LEN  = 16;
  localparam int NUM_CHARS = 32;

  // Data write to DDRAM: RS=1, RW=0, character code in the low byte.
  function automatic logic [9:0] char_word(input logic [7:0] c);
    logic [9:0] w;
    w         = '0;
    w[RS_BIT] = 1'b1;
    w[RW_BIT] = 1'b0;
    w[7:0]    = c;
    return w;
  endfunction
endpackage

// File: rtl/lcd_frame_buffer.sv
// 32x8 character frame buffer: one write port, one combinational read port.
// Resets to spaces so an unwritten panel refreshes blank.
module lcd_frame_buffer
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [4:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_data_o
);
  logic [NUM_CHARS-1:0][7:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     mem_q <= {NUM_CHARS{8'h20}};
    else if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/lcd_text_writer.sv
// Streams the 2x16 frame buffer to the LCD command controller, one word per handshake.
// Define LCD_WRITER_CLEAR_EN to prefix each refresh with a clear and a settle delay.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int FREQ          = 50,
  parameter int CLEAR_WAIT_US = 1600
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [4:0] WR_ADDR,
  input  logic [7:0] WR_CHAR,
  input  logic       UPDATE,
  input  logic       LCD_RDY,
  output logic       LCD_ENB,
  output logic [9:0] LCD_DATA_OUT,
  output logic       BUSY,
  output logic       DONE
);
`ifdef LCD_WRITER_CLEAR_EN
  localparam logic [5:0]  STEP_OFF = 6'd1;
  localparam logic [20:0] DLY_LAST = 21'(CLEAR_WAIT_US * FREQ - 1);
`else
  localparam logic [5:0]  STEP_OFF = 6'd0;
  localparam int          unused_dly = FREQ * CLEAR_WAIT_US;
`endif
  localparam logic [5:0]  LAST_STEP = 6'd33 + STEP_OFF;

  state_e     state_q, state_d;
  logic [5:0] step_q, step_d, idx;
  logic       pend_q, pend_d;
  logic [9:0] data_q, data_d, word;
  logic       busy_q, done_q, done_d;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
`ifdef LCD_WRITER_CLEAR_EN
  logic [20:0] cnt_q, cnt_d;
`endif

  lcd_frame_buffer u_fb (
    .clk_i     (CLOCK_50),
    .rst_i     (RST),
    .we_i      (WR_EN),
    .wr_addr_i (WR_ADDR),
    .wr_data_i (WR_CHAR),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_char)
  );

  // idx 0 and 17 are the line address commands; the rest map onto buffer slots.
  always_comb begin
    idx     = step_q - STEP_OFF;
    rd_addr = (idx <= 6'd16) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
    word    = char_word(rd_char);
    if (idx == 6'd0)       word = CMD_LINE1;
    else if (idx == 6'd17) word = CMD_LINE2;
`ifdef LCD_WRITER_CLEAR_EN
    if (step_q == 6'd0)    word = CMD_CLEAR;
`endif
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pend_d  = pend_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef LCD_WRITER_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    if (UPDATE && state_q != IDLE) pend_d = 1'b1;
    case (state_q)
      IDLE: if (UPDATE || pend_q) begin
        pend_d  = 1'b0;
        step_d  = 6'd0;
        state_d = LOAD;
      end
      LOAD: begin
        data_d = word;
        if (LCD_RDY) state_d = ISSUE;
      end
      ISSUE: state_d = HOLD;
      // RDY from the controller is registered, so it still reads high here.
      HOLD:  state_d = WAIT;
      WAIT: if (LCD_RDY) begin
        if (step_q == LAST_STEP) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef LCD_WRITER_CLEAR_EN
        else if (step_q == 6'd0) begin
          cnt_d   = '0;
          state_d = CLR_DLY;
        end
`endif
        else begin
          step_d  = step_q + 6'd1;
          state_d = LOAD;
        end
      end
`ifdef LCD_WRITER_CLEAR_EN
      CLR_DLY: begin
        if (cnt_q == DLY_LAST) begin
          step_d  = step_q + 6'd1;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q <= IDLE;
      step_q  <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

`ifdef LCD_WRITER_CLEAR_EN
  always_ff @(posedge CLOCK_50) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign LCD_ENB      = (state_q == ISSUE);
  assign LCD_DATA_OUT = data_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
endmodule

// File: tb/tb_lcd_text_writer.sv
// Self-checking bench for lcd_text_writer: controller model with a fixed busy time,
// frame-buffer mirror, and expected word streams built from the refresh rules.
module tb_lcd_text_writer;
`ifdef LCD_WRITER_CLEAR_EN
  localparam int OFF = 1, P_FREQ = 1, P_CW = 100;
`else
  localparam int OFF = 0, P_FREQ = 50, P_CW = 1600;
`endif
  localparam int NW       = 34 + OFF;
  localparam int BUSY_CYC = 20;
  localparam int TMO      = 5000;

  logic       clk = 0, rst = 1, wr_en = 0, update = 0, rdy = 1;
  logic [4:0] wr_addr = 0;
  logic [7:0] wr_char = 0;
  logic       enb, busy, done;
  logic [9:0] dout;

  int checks = 0, errors = 0, cyc = 0;
  logic [9:0] words[$];
  logic [9:0] exp_q[$];
  int enb_cyc[$], rise_cyc[$], done_cycs[$];
  int done_cnt = 0, busy_cnt = 0;
  logic prev_enb = 0;
  logic [7:0] mirror[32];

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] ch;
    int         widx;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[9];

  lcd_text_writer #(.FREQ(P_FREQ), .CLEAR_WAIT_US(P_CW)) dut (
    .CLOCK_50(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_CHAR(wr_char),
    .UPDATE(update), .LCD_RDY(rdy), .LCD_ENB(enb), .LCD_DATA_OUT(dout),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Controller model: RDY drops after each strobe, returns after BUSY_CYC cycles.
  always @(negedge clk) begin
    if (rst) begin
      rdy = 1; busy_cnt = 0;
    end else if (enb) begin
      check("enb_while_rdy_low", rdy, 1'b1);
      check("enb_consecutive", prev_enb, 1'b0);
      words.push_back(dout);
      enb_cyc.push_back(cyc);
      rdy = 0; busy_cnt = BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin rdy = 1; rise_cyc.push_back(cyc); end
    end
    prev_enb = enb;
    if (done) begin done_cnt++; done_cycs.push_back(cyc); end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] c);
    wr_en = 1; wr_addr = a; wr_char = c;
    tick();
    wr_en = 0;
    mirror[a] = c;
  endtask

  task automatic clear_log();
    words.delete(); enb_cyc.delete(); rise_cyc.delete(); done_cycs.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_update();
    update = 1; tick(); update = 0;
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (words.size() < n && t < TMO) begin tick(); t++; end
    check("wait_words_timeout", words.size() >= n, 1'b1);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < TMO) begin tick(); t++; end
    check("wait_done_timeout", done_cnt >= n, 1'b1);
  endtask

  function automatic void mirror_reset();
    for (int i = 0; i < 32; i++) mirror[i] = 8'h20;
  endfunction

  function automatic void build_exp();
    exp_q.delete();
    if (OFF != 0) exp_q.push_back(10'h001);
    for (int l = 0; l < 2; l++) begin
      exp_q.push_back(l == 0 ? 10'h080 : 10'h0C0);
      for (int i = 0; i < 16; i++) exp_q.push_back({2'b10, mirror[l*16+i]});
    end
  endfunction

  task automatic cmp_exp(input string name, input int base);
    for (int i = 0; i < NW && base + i < words.size(); i++)
      check($sformatf("%s_w%0d", name, base + i), words[base+i], exp_q[i]);
  endtask

  initial begin
    int u, n, gap;
    logic [7:0] old;

    tbl[0] = '{1'b1, 5'd0, 8'h48, 1,  10'h248};
    tbl[1] = '{1'b1, 5'd1, 8'h45, 2,  10'h245};
    tbl[2] = '{1'b1, 5'd2, 8'h4C, 3,  10'h24C};
    tbl[3] = '{1'b1, 5'd3, 8'h4C, 4,  10'h24C};
    tbl[4] = '{1'b1, 5'd4, 8'h4F, 5,  10'h24F};
    tbl[5] = '{1'b0, 5'd0, 8'h00, 0,  10'h080};
    tbl[6] = '{1'b0, 5'd0, 8'h00, 6,  10'h220};
    tbl[7] = '{1'b0, 5'd0, 8'h00, 17, 10'h0C0};
    tbl[8] = '{1'b0, 5'd0, 8'h00, 33, 10'h220};

    // Reset
    rst = 1; tick(3); rst = 0;
    mirror_reset();
    check("rst_enb", enb, 1'b0);
    check("rst_data", dout, 10'h000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Blank refresh: buffer reads back as spaces; first strobe latency
    clear_log();
    update = 1; u = cyc; tick(); update = 0;
    wait_done(1);
    tick(5);
    check("first_enb_latency", enb_cyc.size() > 0 ? enb_cyc[0] - u : -1, 2);
    check("blank_count", words.size(), NW);
    check("blank_done_cnt", done_cnt, 1);
    build_exp(); cmp_exp("blank", 0);
`ifdef LCD_WRITER_CLEAR_EN
    gap = (enb_cyc.size() > 1 && rise_cyc.size() > 0) ? enb_cyc[1] - rise_cyc[0] : 0;
    check("clear_settle_ge100", gap >= 100, 1'b1);
`endif

    // Table-driven HELLO refresh
    foreach (tbl[i]) if (tbl[i].we) do_write(tbl[i].addr, tbl[i].ch);
    clear_log();
    pulse_update();
    wait_done(1);
    tick(5);
    check("hello_count", words.size(), NW);
    check("hello_done_cnt", done_cnt, 1);
    foreach (tbl[i])
      check($sformatf("tbl%0d", i), (tbl[i].widx + OFF < words.size()) ? words[tbl[i].widx+OFF] : 10'h3FF, tbl[i].exp);

    // Write to line 2 while line 1 is still streaming
    clear_log();
    pulse_update();
    wait_words(OFF + 5);
    do_write(5'd31, 8'h5A);
    wait_done(1);
    tick(5);
    check("wdr_last_word", words.size() == NW ? words[NW-1] : 10'h3FF, 10'h25A);
    build_exp(); cmp_exp("wdr", 0);

    // Write landing on the same cycle its slot is loaded: old value is sent
    clear_log();
    pulse_update();
    n = 0;
    while (!(words.size() == OFF + 3 && rdy) && n < TMO) begin tick(); n++; end
    check("collide_sync", words.size() == OFF + 3 && rdy, 1'b1);
    old = mirror[2];
    build_exp();
    do_write(5'd2, 8'h71);
    wait_done(1);
    tick(5);
    check("collide_old", words.size() > OFF + 3 ? words[OFF+3] : 10'h3FF, {2'b10, old});
    cmp_exp("collide", 0);

    // Pending: three requests while busy collapse into one extra refresh
    clear_log();
    pulse_update();
    tick(10); pulse_update();
    tick(100); pulse_update();
    wait_words(OFF + 30); pulse_update();
    wait_done(2);
    tick(60);
    check("pend_count", words.size(), 2 * NW);
    check("pend_done_cnt", done_cnt, 2);
    check("pend_idle", busy, 1'b0);
    gap = (enb_cyc.size() > NW && done_cycs.size() > 0) ? enb_cyc[NW] - done_cycs[0] : -1;
    check("pend_restart_gap", gap >= 1 && gap <= 3, 1'b1);
    build_exp(); cmp_exp("pend1", 0); cmp_exp("pend2", NW);

    // Reset mid-refresh
    clear_log();
    pulse_update();
    wait_words(OFF + 10);
    rst = 1; tick(); 
    check("midrst_enb", enb, 1'b0);
    check("midrst_busy", busy, 1'b0);
    rst = 0;
    mirror_reset();
    n = words.size();
    tick(100);
    check("midrst_no_words", words.size(), n);
    check("midrst_busy_after", busy, 1'b0);

    // Randomized refreshes against the mirror
    for (int r = 0; r < 3; r++) begin
      repeat (8) do_write(5'($urandom_range(0, 31)), 8'($urandom_range(8'h21, 8'h7E)));
      clear_log();
      pulse_update();
      for (int k = 0; k < 4; k++) begin
        wait_words(OFF + 2 * k + 1);
        do_write(5'($urandom_range(16, 31)), 8'($urandom_range(8'h21, 8'h7E)));
      end
      wait_done(1);
      tick(5);
      check($sformatf("rand%0d_count", r), words.size(), NW);
      build_exp(); cmp_exp($sformatf("rand%0d", r), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_text_writer.md
# lcd_text_writer

Command source that drives the existing character-LCD command controller's 10-bit DATA/ENB/RDY write interface. Holds a 2×16 character frame buffer written by game logic. On request, streams the buffer to the panel as DDRAM-address commands plus character writes, one handshake per word. Sits between game logic and the LCD controller; the controller's DATA, ENB and RDY ports connect directly to this block's LCD_DATA_OUT, LCD_ENB and LCD_RDY.

## Interface
- FREQ, 50: clock cycles per microsecond.
- CLEAR_WAIT_US, 1600: post-clear settle time in µs. Used only with LCD_WRITER_CLEAR_EN.
- CLOCK_50  in  1  system clock. Everything is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- WR_EN  in  1  frame-buffer write strobe.
- WR_ADDR  in  5  character position. 0–15 is line 1, 16–31 is line 2.
- WR_CHAR  in  8  character code.
- UPDATE  in  1  refresh request. Sampled on any cycle.
- LCD_RDY  in  1  controller ready. Connects to the controller's RDY.
- LCD_ENB  out  1  command strobe. Connects to the controller's ENB.
- LCD_DATA_OUT  out  10  command word {RS, RW, byte}. Connects to the controller's DATA.
- BUSY  out  1  refresh in progress.
- DONE  out  1  one-cycle pulse when a refresh completes.

## Operation
- Frame buffer: 32×8 registers. On reset every entry is 8'h20 (space).
- Writes (WR_EN=1) are accepted on any cycle, including during a refresh.
- A character word carries the buffer content at the cycle the word is loaded.
- Refresh sequence, by step index:
  - Step 0: 10'h080 (set DDRAM address 0x00).
  - Steps 1–16: {2'b10, buf[0..15]}.
  - Step 17: 10'h0C0 (set DDRAM address 0x40).
  - Steps 18–33: {2'b10, buf[16..31]}.
  - Total: 34 words. RW is always 0.
- State machine:
  - IDLE. If UPDATE or pending is set, clear pending, set step=0 and go to LOAD.
  - LOAD. Register LCD_DATA_OUT for the current step. Go to ISSUE when LCD_RDY=1; otherwise stay.
  - ISSUE. LCD_ENB=1 for exactly this cycle. Go to HOLD.
  - HOLD. One cycle in which LCD_RDY is ignored, covering the controller's registered RDY fall. Go to WAIT.
  - WAIT. Stay until LCD_RDY=1. Then:
    - if step=33: pulse DONE and go to IDLE;
    - otherwise: increment step and go to LOAD.
- UPDATE while BUSY sets a single pending flag. Multiple requests collapse into one extra refresh, which starts right after DONE.
- UPDATE in the same cycle as DONE also sets pending.
- Write and refresh at the same position: if WR_EN hits a position in the same cycle that position is loaded, the old value is sent. The new value goes out on the next refresh.
- Step counter is 6 bits and never wraps; the terminal step is compared explicitly.

## Timing
- Reset values: LCD_ENB=0, LCD_DATA_OUT=10'h000, BUSY=0, DONE=0, state=IDLE, step=0, pending=0.
- RST mid-refresh: the sequence is abandoned. LCD_ENB=0 from the next edge. The buffer returns to spaces. A partially written panel is accepted.
- BUSY is registered. It is high in every state other than IDLE.
- First LCD_ENB appears 2 cycles after UPDATE is sampled in IDLE with LCD_RDY=1.
- LCD_DATA_OUT is stable from the LOAD cycle through the end of HOLD. Between words it holds its last value.
- LCD_ENB is never high for two consecutive cycles. It is never asserted while LCD_RDY=0.
- Minimum per-word overhead is 3 cycles plus the controller's busy time (about 50 µs at FREQ=50).

## Configuration
- LCD_WRITER_CLEAR_EN, when defined:
  - The refresh is prefixed with 10'h001 (clear display) as step 0, and the sequence above shifts to steps 1–34.
  - After the clear word's WAIT completes, the FSM enters CLR_DLY and counts CLEAR_WAIT_US×FREQ cycles before the next LOAD.
  - The counter is 21 bits. BUSY stays high during CLR_DLY.
  - RST clears the counter.
- LCD_WRITER_CLEAR_EN, when undefined: no clear word, no CLR_DLY state, no delay counter. Refresh is exactly 34 words.

## Structure
- Shared package lcd_pkg holds:
  - state enum (IDLE, LOAD, ISSUE, HOLD, WAIT, CLR_DLY);
  - command constants CMD_LINE1=10'h080, CMD_LINE2=10'h0C0, CMD_CLEAR=10'h001;
  - RS/RW field positions;
  - LINE_LEN=16 and NUM_CHARS=32.
- One sub-module, lcd_frame_buffer: the 32×8 register file with reset to 8'h20, one write port and one asynchronous read port addressed by step.

## Test plan
- Reset check: assert RST 3 cycles, then release. LCD_ENB=0, LCD_DATA_OUT=000, BUSY=0, DONE=0; a read-back of any buffer entry gives 8'h20.
- Single refresh: controller model holds RDY low 20 cycles per word. Write "HELLO" at 0–4, pulse UPDATE. Expect exactly 34 ENB pulses: 080, 248, 245, 24C, 24C, 24F, 220…, then 0C0, 16×220. DONE pulses once.
- Write during refresh: write 'Z' at position 31 while step<18. Line-2 final word is 25A.
- Pending: pulse UPDATE three times while BUSY. Expect exactly one further 34-word refresh starting right after DONE, then IDLE.
- Reset mid-operation: assert RST at step 10. LCD_ENB stays 0 from the next cycle, BUSY=0, and no further words are issued.
- LCD_WRITER_CLEAR_EN defined, with FREQ=1 and CLEAR_WAIT_US=100:
  - the first word is 001;
  - at least 100 cycles pass between RDY returning high and the ENB carrying 080;
  - 35 words in total.
